// File: rtl/branch_comp.sv
// RV32I branch comparator: combinational eq/lt flags plus a one-cycle registered copy.
// Optional BRANCHCOMP_TAKEN_EN adds funct3 decode to br_taken/br_taken_q.
module branch_comp #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            br_un,
    input  logic            in_valid,
`ifdef BRANCHCOMP_TAKEN_EN
    input  logic [2:0]      funct3,
    output logic            br_taken,
    output logic            br_taken_q,
`endif
    output logic            br_eq,
    output logic            br_lt,
    output logic            out_valid,
    output logic            br_eq_q,
    output logic            br_lt_q
);

    logic w_eq;
    logic w_sgn_diff;
    logic w_low_lt;
    logic w_lt_u;
    logic w_lt_s;
    logic w_lt;

    logic r_valid;
    logic r_eq;
    logic r_lt;

    // Direct magnitude compare, never the sign of a-b, so no overflow cases.
    assign w_eq       = (a == b);
    assign w_sgn_diff = a[XLEN-1] ^ b[XLEN-1];
    assign w_low_lt   = (a[XLEN-2:0] < b[XLEN-2:0]);
    assign w_lt_u     = w_sgn_diff ? b[XLEN-1] : w_low_lt;
    assign w_lt_s     = w_sgn_diff ? a[XLEN-1] : w_low_lt;
    assign w_lt       = !w_eq && (br_un ? w_lt_u : w_lt_s);

    assign br_eq = w_eq;
    assign br_lt = w_lt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_eq <= w_eq;
                r_lt <= w_lt;
            end
        end
    end

    assign out_valid = r_valid;
    assign br_eq_q   = r_eq;
    assign br_lt_q   = r_lt;

`ifdef BRANCHCOMP_TAKEN_EN
    logic w_lt_f3;
    logic w_taken;
    logic r_taken;

    // funct3[1] picks unsigned for BLTU/BGEU regardless of br_un.
    assign w_lt_f3 = !w_eq && (funct3[1] ? w_lt_u : w_lt_s);

    always_comb begin
        w_taken = 1'b0;
        unique case (funct3)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = !w_eq;
            3'b100:  w_taken = w_lt_f3;
            3'b101:  w_taken = !w_lt_f3;
            3'b110:  w_taken = w_lt_f3;
            3'b111:  w_taken = !w_lt_f3;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken <= 1'b0;
        end else if (in_valid) begin
            r_taken <= w_taken;
        end
    end

    assign br_taken   = w_taken;
    assign br_taken_q = r_taken;
`endif

endmodule

// File: tb/tb_branch_comp.sv
// Directed bench for branch_comp: combinational flags, registered path, async reset.
`timescale 1ns/1ps
module tb_branch_comp;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        br_un;
    logic        in_valid;
    logic        br_eq;
    logic        br_lt;
    logic        out_valid;
    logic        br_eq_q;
    logic        br_lt_q;
`ifdef BRANCHCOMP_TAKEN_EN
    logic [2:0]  funct3;
    logic        br_taken;
    logic        br_taken_q;
`endif

    int total;
    int bad;

    branch_comp #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .br_un     (br_un),
        .in_valid  (in_valid),
`ifdef BRANCHCOMP_TAKEN_EN
        .funct3    (funct3),
        .br_taken  (br_taken),
        .br_taken_q(br_taken_q),
`endif
        .br_eq     (br_eq),
        .br_lt     (br_lt),
        .out_valid (out_valid),
        .br_eq_q   (br_eq_q),
        .br_lt_q   (br_lt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        un;
        logic        eq;
        logic        lt;
    } vec_t;

    vec_t vecs[] = '{
        '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 1'b0},
        '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 1'b0},
        '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1},
        '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0},
        '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1},
        '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0},
        '{32'h00000003, 32'h00000007, 1'b0, 1'b0, 1'b1},
        '{32'h00000003, 32'h00000007, 1'b1, 1'b0, 1'b1},
        '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1},
        '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0},
        '{32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b0},
        '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b1},
        '{32'h80000000, 32'h80000001, 1'b0, 1'b0, 1'b1},
        '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1},
        '{32'h00000009, 32'h00000002, 1'b1, 1'b0, 1'b0}
    };

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        br_un    = 1'b0;
        in_valid = 1'b0;
`ifdef BRANCHCOMP_TAKEN_EN
        funct3   = 3'b000;
`endif
        #2;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_eq_q",  {31'b0, br_eq_q},   32'd0);
        chk("rst_lt_q",  {31'b0, br_lt_q},   32'd0);

        // Combinational path is live while in reset.
        a = 32'hFFFFFFFF; b = 32'h00000001; br_un = 1'b0;
        #1;
        chk("rst_comb_eq", {31'b0, br_eq}, 32'd0);
        chk("rst_comb_lt", {31'b0, br_lt}, 32'd1);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            a = vecs[i].va; b = vecs[i].vb; br_un = vecs[i].un;
            #1;
            chk($sformatf("v%0d_eq", i), {31'b0, br_eq}, {31'b0, vecs[i].eq});
            chk($sformatf("v%0d_lt", i), {31'b0, br_lt}, {31'b0, vecs[i].lt});
        end

        // Registered path, edge N.
        @(negedge clk);
        a = 32'd2; b = 32'd9; br_un = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("regN_valid", {31'b0, out_valid}, 32'd1);
        chk("regN_eq_q",  {31'b0, br_eq_q},   32'd0);
        chk("regN_lt_q",  {31'b0, br_lt_q},   32'd1);

        // Edge N+1 with in_valid low: flags hold despite new operands.
        @(negedge clk);
        a = 32'd9; b = 32'd9; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("regN1_valid", {31'b0, out_valid}, 32'd0);
        chk("regN1_eq_q",  {31'b0, br_eq_q},   32'd0);
        chk("regN1_lt_q",  {31'b0, br_lt_q},   32'd1);

        @(negedge clk);
        a = 32'd7; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("reg2_valid", {31'b0, out_valid}, 32'd1);
        chk("reg2_eq_q",  {31'b0, br_eq_q},   32'd1);
        chk("reg2_lt_q",  {31'b0, br_lt_q},   32'd0);

        // Async reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_eq_q",  {31'b0, br_eq_q},   32'd0);
        chk("arst_lt_q",  {31'b0, br_lt_q},   32'd0);
        a = 32'd1; b = 32'd4; br_un = 1'b0;
        #1;
        chk("arst_eq", {31'b0, br_eq}, 32'd0);
        chk("arst_lt", {31'b0, br_lt}, 32'd1);
        @(posedge clk); #1;
        chk("arst_hold_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_hold_eq_q",  {31'b0, br_eq_q},   32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_valid", {31'b0, out_valid}, 32'd0);
        chk("post_lt_q",  {31'b0, br_lt_q},   32'd0);

        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("post2_valid", {31'b0, out_valid}, 32'd1);
        chk("post2_lt_q",  {31'b0, br_lt_q},   32'd1);

`ifdef BRANCHCOMP_TAKEN_EN
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'hFFFFFFFE; b = 32'h00000001; br_un = 1'b1;
        funct3 = 3'b101; #1;
        chk("bge",  {31'b0, br_taken}, 32'd0);
        funct3 = 3'b111; #1;
        chk("bgeu", {31'b0, br_taken}, 32'd1);
        funct3 = 3'b001; #1;
        chk("bne",  {31'b0, br_taken}, 32'd1);
        funct3 = 3'b000; #1;
        chk("beq",  {31'b0, br_taken}, 32'd0);
        funct3 = 3'b010; #1;
        chk("f010", {31'b0, br_taken}, 32'd0);
        br_un = 1'b0;
        funct3 = 3'b110; #1;
        chk("bltu", {31'b0, br_taken}, 32'd0);
        funct3 = 3'b100; #1;
        chk("blt",  {31'b0, br_taken}, 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("blt_q", {31'b0, br_taken_q}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
